// File: rtl/mem_io_map_pkg.sv
// Shared address map, status bit positions and LCD fill value for the mem_io_map block.
package mem_io_pkg;

  localparam logic [15:0] RAM_BASE           = 16'h0000;
  localparam logic [15:0] RAM_LIMIT          = 16'h0FFF;
  localparam logic [15:0] LCD_BASE           = 16'hF000;
  localparam logic [15:0] LCD_LIMIT          = 16'hF01F;
  localparam logic [15:0] ADDR_LED_RED       = 16'hF060;
  localparam logic [15:0] ADDR_LED_GREEN     = 16'hF061;
  localparam logic [15:0] ADDR_HEX3_HEX0     = 16'hF062;
  localparam logic [15:0] ADDR_HEX7_HEX4     = 16'hF063;
  localparam logic [15:0] ADDR_SWITCH        = 16'hF064;
  localparam logic [15:0] ADDR_BUTTON        = 16'hF065;
  localparam logic [15:0] ADDR_UART_TX_DATA  = 16'hF070;
  localparam logic [15:0] ADDR_UART_TX_STAT  = 16'hF071;
  localparam logic [15:0] ADDR_UART_RX_DATA  = 16'hF072;
  localparam logic [15:0] ADDR_UART_RX_STAT  = 16'hF073;

  localparam int TX_BUSY_BIT  = 0;
  localparam int RX_VALID_BIT = 0;
  localparam int RX_FERR_BIT  = 1;
  localparam int RX_OVR_BIT   = 2;

  localparam logic [7:0] LCD_BLANK = 8'h20;

  // Bit order matches the RX status register: {overrun, framing error, valid}.
  typedef struct packed {
    logic overrun;
    logic frameErr;
    logic valid;
  } rx_status_t;

endpackage

// File: rtl/mem_io_map_if.sv
// CPU load/store port: word address, write data/enable and registered read data.
interface mem_io_map_if;
  logic [15:0] addr;
  logic [15:0] din;
  logic        we;
  logic [15:0] dout;

  modport master (output addr, output din, output we, input dout);
  modport slave  (input addr, input din, input we, output dout);
endinterface

// File: rtl/mem_io_map_uart.sv
// 8N1 UART transmitter and receiver, only instantiated when MEM_IO_UART_EN is defined.
module mem_io_uart
  import mem_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       txStart_i,
  input  logic [7:0] txData_i,
  output logic       txBusy_o,
  output logic       tx_o,
  input  logic       rx_i,
  input  logic       rxRead_i,
  input  logic       rxClear_i,
  output logic [7:0] rxData_o,
  output rx_status_t rxStatus_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]    txState_q, txState_d;
  logic [CW-1:0] txCnt_q, txCnt_d;
  logic [2:0]    txBit_q, txBit_d;
  logic [7:0]    txShift_q, txShift_d;
  logic          tx_q, tx_d;

  logic [1:0]    rxSync_q;
  logic          rxPrev_q;
  logic [1:0]    rxState_q, rxState_d;
  logic [CW-1:0] rxCnt_q, rxCnt_d;
  logic [2:0]    rxBit_q, rxBit_d;
  logic [7:0]    rxShift_q, rxShift_d;
  logic [7:0]    rxData_q, rxData_d;
  rx_status_t    rxStat_q, rxStat_d;

  // The line register is loaded together with the state so tx_o changes exactly on bit boundaries.
  always_comb begin
    txState_d = txState_q;
    txCnt_d   = txCnt_q;
    txBit_d   = txBit_q;
    txShift_d = txShift_q;
    tx_d      = tx_q;
    case (txState_q)
      ST_IDLE: if (txStart_i) begin
        txState_d = ST_START;
        txCnt_d   = '0;
        txShift_d = txData_i;
        tx_d      = 1'b0;
      end
      ST_START: if (txCnt_q == BIT_LAST) begin
        txState_d = ST_DATA;
        txCnt_d   = '0;
        txBit_d   = '0;
        tx_d      = txShift_q[0];
      end else txCnt_d = txCnt_q + 1'b1;
      ST_DATA: if (txCnt_q == BIT_LAST) begin
        txCnt_d = '0;
        if (txBit_q == 3'd7) begin
          txState_d = ST_STOP;
          tx_d      = 1'b1;
        end else begin
          txBit_d   = txBit_q + 1'b1;
          txShift_d = {1'b0, txShift_q[7:1]};
          tx_d      = txShift_q[1];
        end
      end else txCnt_d = txCnt_q + 1'b1;
      default: if (txCnt_q == BIT_LAST) txState_d = ST_IDLE;
               else txCnt_d = txCnt_q + 1'b1;
    endcase
  end

  // A completed byte is applied after the CPU-side clears, so a same-cycle arrival keeps rx_valid set.
  always_comb begin
    rxState_d = rxState_q;
    rxCnt_d   = rxCnt_q;
    rxBit_d   = rxBit_q;
    rxShift_d = rxShift_q;
    rxData_d  = rxData_q;
    rxStat_d  = rxStat_q;
    if (rxRead_i) rxStat_d.valid = 1'b0;
    if (rxClear_i) begin
      rxStat_d.frameErr = 1'b0;
      rxStat_d.overrun  = 1'b0;
    end
    case (rxState_q)
      ST_IDLE: if (rxPrev_q && !rxSync_q[1]) begin
        rxState_d = ST_START;
        rxCnt_d   = '0;
      end
      ST_START: if (rxCnt_q == BIT_HALF) begin
        rxState_d = rxSync_q[1] ? ST_IDLE : ST_DATA;
        rxCnt_d   = '0;
        rxBit_d   = '0;
      end else rxCnt_d = rxCnt_q + 1'b1;
      ST_DATA: if (rxCnt_q == BIT_LAST) begin
        rxCnt_d   = '0;
        rxShift_d = {rxSync_q[1], rxShift_q[7:1]};
        if (rxBit_q == 3'd7) rxState_d = ST_STOP;
        else rxBit_d = rxBit_q + 1'b1;
      end else rxCnt_d = rxCnt_q + 1'b1;
      default: if (rxCnt_q == BIT_LAST) begin
        rxState_d = ST_IDLE;
        if (rxSync_q[1]) begin
          rxData_d         = rxShift_q;
          rxStat_d.valid   = 1'b1;
          rxStat_d.overrun = rxStat_d.overrun | (rxStat_q.valid & ~rxRead_i);
        end else rxStat_d.frameErr = 1'b1;
      end else rxCnt_d = rxCnt_q + 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txState_q <= ST_IDLE;
      txCnt_q   <= '0;
      txBit_q   <= '0;
      txShift_q <= '0;
      tx_q      <= 1'b1;
      rxSync_q  <= 2'b11;
      rxPrev_q  <= 1'b1;
      rxState_q <= ST_IDLE;
      rxCnt_q   <= '0;
      rxBit_q   <= '0;
      rxShift_q <= '0;
      rxData_q  <= '0;
      rxStat_q  <= '0;
    end else begin
      txState_q <= txState_d;
      txCnt_q   <= txCnt_d;
      txBit_q   <= txBit_d;
      txShift_q <= txShift_d;
      tx_q      <= tx_d;
      rxSync_q  <= {rxSync_q[0], rx_i};
      rxPrev_q  <= rxSync_q[1];
      rxState_q <= rxState_d;
      rxCnt_q   <= rxCnt_d;
      rxBit_q   <= rxBit_d;
      rxShift_q <= rxShift_d;
      rxData_q  <= rxData_d;
      rxStat_q  <= rxStat_d;
    end
  end

  assign txBusy_o   = (txState_q != ST_IDLE);
  assign tx_o       = tx_q;
  assign rxData_o   = rxData_q;
  assign rxStatus_o = rxStat_q;

endmodule

// File: rtl/mem_io_map.sv
// Address decode, RAM, LCD buffer and board peripheral registers for the soft CPU.
// The UART at 0xF070-0xF073 is only built when MEM_IO_UART_EN is defined.
module mem_io_map
  import mem_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int RAM_AW       = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_io_map_if.slave bus,
  input  logic [15:0] switch,
  input  logic [3:0]  button,
  output logic [15:0] led_red,
  output logic [7:0]  led_green,
  output logic [15:0] hex7_hex4,
  output logic [15:0] hex3_hex0,
  input  logic [4:0]  lcd_index,
  output logic [7:0]  lcd_char,
  input  logic        rx_serial,
  output logic        tx_serial
);

  logic [15:0] ram [0:(1 << RAM_AW) - 1];
  logic [7:0]  lcd_q [0:31];
  logic [15:0] ledRed_q, hexLo_q, hexHi_q, dout_q, readData_d;
  logic [7:0]  ledGreen_q;
  logic        isRam, isLcd;
  logic        txBusy;
  logic [7:0]  rxData;
  rx_status_t  rxStatus;

  assign isRam = (bus.addr[15:RAM_AW] == '0);
  assign isLcd = (bus.addr[15:5] == LCD_BASE[15:5]);

`ifdef MEM_IO_UART_EN
  mem_io_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) uUart (
    .clk        (clk),
    .rst_n      (rst_n),
    .txStart_i  (bus.we && bus.addr == ADDR_UART_TX_DATA),
    .txData_i   (bus.din[7:0]),
    .txBusy_o   (txBusy),
    .tx_o       (tx_serial),
    .rx_i       (rx_serial),
    .rxRead_i   (!bus.we && bus.addr == ADDR_UART_RX_DATA),
    .rxClear_i  (bus.we && bus.addr == ADDR_UART_RX_STAT),
    .rxData_o   (rxData),
    .rxStatus_o (rxStatus)
  );
`else
  localparam int unusedClksPerBit = CLKS_PER_BIT;
  logic unusedRx;
  assign unusedRx  = rx_serial;
  assign txBusy    = 1'b0;
  assign rxData    = '0;
  assign rxStatus  = '0;
  assign tx_serial = 1'b1;
`endif

  // RAM is deliberately left out of reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (bus.we && isRam) ram[bus.addr[RAM_AW-1:0]] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ledRed_q   <= '0;
      ledGreen_q <= '0;
      hexLo_q    <= '0;
      hexHi_q    <= '0;
      for (int i = 0; i < 32; i++) lcd_q[i] <= LCD_BLANK;
    end else if (bus.we) begin
      if (isLcd) lcd_q[bus.addr[4:0]] <= bus.din[7:0];
      case (bus.addr)
        ADDR_LED_RED:   ledRed_q   <= bus.din;
        ADDR_LED_GREEN: ledGreen_q <= bus.din[7:0];
        ADDR_HEX3_HEX0: hexLo_q    <= bus.din;
        ADDR_HEX7_HEX4: hexHi_q    <= bus.din;
        default: ;
      endcase
    end
  end

  // The mux sees pre-write state, which gives read-before-write on a shared edge.
  always_comb begin
    readData_d = '0;
    if (isRam) readData_d = ram[bus.addr[RAM_AW-1:0]];
    else if (isLcd) readData_d = {8'h00, lcd_q[bus.addr[4:0]]};
    else begin
      case (bus.addr)
        ADDR_LED_RED:      readData_d = ledRed_q;
        ADDR_LED_GREEN:    readData_d = {8'h00, ledGreen_q};
        ADDR_HEX3_HEX0:    readData_d = hexLo_q;
        ADDR_HEX7_HEX4:    readData_d = hexHi_q;
        ADDR_SWITCH:       readData_d = switch;
        ADDR_BUTTON:       readData_d = {12'h000, button};
        ADDR_UART_TX_STAT: readData_d[TX_BUSY_BIT] = txBusy;
        ADDR_UART_RX_DATA: readData_d = {8'h00, rxData};
        ADDR_UART_RX_STAT: readData_d = {13'h0000, rxStatus};
        default:           readData_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) dout_q <= '0;
    else        dout_q <= readData_d;
  end

  assign bus.dout  = dout_q;
  assign led_red   = ledRed_q;
  assign led_green = ledGreen_q;
  assign hex3_hex0 = hexLo_q;
  assign hex7_hex4 = hexHi_q;
  assign lcd_char  = lcd_q[lcd_index];

endmodule

// File: tb/tb_mem_io_map.sv
// Randomised directed bench for mem_io_map with a behavioural model of the memory map and UART.
module tb_mem_io_map;

  localparam int CPB = 4;
`ifdef MEM_IO_UART_EN
  localparam bit UART_EN = 1'b1;
`else
  localparam bit UART_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] switch;
  logic [3:0]  button;
  logic [15:0] led_red, hex7_hex4, hex3_hex0;
  logic [7:0]  led_green, lcd_char;
  logic [4:0]  lcd_index;
  logic        rx_serial, tx_serial;

  mem_io_map_if bus();

  mem_io_map #(.CLKS_PER_BIT(CPB), .RAM_AW(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .switch    (switch),
    .button    (button),
    .led_red   (led_red),
    .led_green (led_green),
    .hex7_hex4 (hex7_hex4),
    .hex3_hex0 (hex3_hex0),
    .lcd_index (lcd_index),
    .lcd_char  (lcd_char),
    .rx_serial (rx_serial),
    .tx_serial (tx_serial)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Behavioural model state
  logic [15:0] ramModel [0:4095];
  logic [7:0]  lcdModel [0:31];
  logic [15:0] redM, hexLoM, hexHiM;
  logic [7:0]  greenM, rxDataM, txByteM;
  bit          rxValidM, rxFerrM, rxOvrM;
  int          txStartEdge;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%h expected=0x%h", tag, observed, expected);
    end
  endtask

  function automatic bit txBusyAt(input int n);
    return UART_EN && (n > txStartEdge) && (n <= txStartEdge + 10 * CPB);
  endfunction

  // Line level after edge n: frame is start, 8 data bits LSB first, stop.
  function automatic logic txLineAt(input int n);
    int k;
    if (!UART_EN || n < txStartEdge || n >= txStartEdge + 10 * CPB) return 1'b1;
    k = (n - txStartEdge) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return txByteM[k-1];
  endfunction

  task automatic modelReset();
    redM = '0; greenM = '0; hexLoM = '0; hexHiM = '0;
    for (int i = 0; i < 32; i++) lcdModel[i] = 8'h20;
    rxDataM = '0; rxValidM = 0; rxFerrM = 0; rxOvrM = 0;
    txStartEdge = -1000;
  endtask

  task automatic modelWrite(input logic [15:0] a, input logic [15:0] d);
    int n;
    n = cycleCount + 1;
    if (a < 16'h1000) ramModel[a[11:0]] = d;
    else if (a >= 16'hF000 && a <= 16'hF01F) lcdModel[a[4:0]] = d[7:0];
    else case (a)
      16'hF060: redM = d;
      16'hF061: greenM = d[7:0];
      16'hF062: hexLoM = d;
      16'hF063: hexHiM = d;
      16'hF070: if (UART_EN && !txBusyAt(n)) begin txStartEdge = n; txByteM = d[7:0]; end
      16'hF073: begin rxFerrM = 0; rxOvrM = 0; end
      default: ;
    endcase
  endtask

  task automatic modelRead(input logic [15:0] a, output logic [15:0] exp);
    exp = '0;
    if (a < 16'h1000) exp = ramModel[a[11:0]];
    else if (a >= 16'hF000 && a <= 16'hF01F) exp = {8'h00, lcdModel[a[4:0]]};
    else case (a)
      16'hF060: exp = redM;
      16'hF061: exp = {8'h00, greenM};
      16'hF062: exp = hexLoM;
      16'hF063: exp = hexHiM;
      16'hF064: exp = switch;
      16'hF065: exp = {12'h000, button};
      16'hF071: exp = {15'h0000, txBusyAt(cycleCount + 1)};
      16'hF072: begin exp = {8'h00, rxDataM}; rxValidM = 0; end
      16'hF073: exp = {13'h0000, rxOvrM, rxFerrM, rxValidM};
      default: exp = '0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d, input logic w);
    bus.addr = a; bus.din = d; bus.we = w;
    tick();
    bus.we = 1'b0; bus.addr = 16'h0000; bus.din = 16'h0000;
  endtask

  task automatic busWrite(input logic [15:0] a, input logic [15:0] d);
    modelWrite(a, d);
    applyStimulus(a, d, 1'b1);
  endtask

  task automatic busReadCheck(input string tag, input logic [15:0] a);
    logic [15:0] exp;
    modelRead(a, exp);
    applyStimulus(a, 16'h0000, 1'b0);
    checkOutput(tag, bus.dout, exp);
  endtask

  task automatic sendRxFrame(input logic [7:0] b, input bit stopBit);
    rx_serial = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (CPB) tick();
    end
    rx_serial = stopBit;
    repeat (CPB) tick();
    rx_serial = 1'b1;
    repeat (3 * CPB) tick();
    if (UART_EN) begin
      if (stopBit) begin
        rxOvrM   = rxOvrM | rxValidM;
        rxValidM = 1;
        rxDataM  = b;
      end else rxFerrM = 1;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] a, d, exp;
    logic [4:0]  idx;
    logic [7:0]  b1, b2;

    bus.addr = '0; bus.din = '0; bus.we = 1'b0;
    rst_n = 1'b0; rx_serial = 1'b1; switch = '0; button = '0; lcd_index = '0;
    modelReset();

    repeat (3) tick();
    checkOutput("reset_dout", bus.dout, 16'h0000);
    checkOutput("reset_tx", {15'h0, tx_serial}, 16'h0001);
    checkOutput("reset_led_red", led_red, 16'h0000);
    checkOutput("reset_led_green", {8'h0, led_green}, 16'h0000);
    checkOutput("reset_hex_lo", hex3_hex0, 16'h0000);
    checkOutput("reset_hex_hi", hex7_hex4, 16'h0000);
    lcd_index = 5'd0; #1;
    checkOutput("reset_lcd0", {8'h0, lcd_char}, 16'h0020);
    lcd_index = 5'd31; #1;
    checkOutput("reset_lcd31", {8'h0, lcd_char}, 16'h0020);
    rst_n = 1'b1;
    tick();

    // Walk of all-ones writes, including read-only and UART addresses
    busWrite(16'hF060, 16'hFFFF);
    busWrite(16'hF070, 16'hFFFF);
    busWrite(16'hF071, 16'hFFFF);
    busWrite(16'hF063, 16'hFFFF);
    busWrite(16'hF072, 16'hFFFF);
    checkOutput("walk_led_red", led_red, redM);
    checkOutput("walk_hex_hi", hex7_hex4, hexHiM);
    checkOutput("walk_hex_lo", hex3_hex0, hexLoM);
    checkOutput("walk_led_green", {8'h0, led_green}, {8'h0, greenM});
    checkOutput("walk_tx_start", {15'h0, tx_serial}, {15'h0, txLineAt(cycleCount)});
    busReadCheck("walk_tx_busy", 16'hF071);
    busReadCheck("walk_rx_stat", 16'hF073);
    repeat (45) tick();
    checkOutput("walk_tx_done", {15'h0, tx_serial}, 16'h0001);

    // RAM: directed, read-before-write and random
    busWrite(16'h0010, 16'h1234);
    busReadCheck("ram_0010", 16'h0010);
    modelRead(16'h0010, exp);
    modelWrite(16'h0010, 16'hBEEF);
    applyStimulus(16'h0010, 16'hBEEF, 1'b1);
    checkOutput("ram_rbw_old", bus.dout, exp);
    busReadCheck("ram_rbw_new", 16'h0010);
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom_range(0, 4095));
      d = 16'($urandom);
      busWrite(a, d);
      busReadCheck("ram_rand", a);
    end
    busWrite(16'h0FFF, 16'h5A5A);
    busReadCheck("ram_top", 16'h0FFF);

    // LCD buffer
    busWrite(16'hF005, 16'h0041);
    lcd_index = 5'd5; #1;
    checkOutput("lcd_char5", {8'h0, lcd_char}, {8'h0, lcdModel[5]});
    for (int i = 0; i < 6; i++) begin
      idx = 5'($urandom_range(0, 31));
      busWrite({11'h780, idx}, 16'($urandom));
      lcd_index = 5'($urandom_range(0, 31)); #1;
      checkOutput("lcd_char_rand", {8'h0, lcd_char}, {8'h0, lcdModel[lcd_index]});
      busReadCheck("lcd_read", {11'h780, idx});
    end

    // Peripheral registers and inputs
    for (int i = 0; i < 4; i++) begin
      busWrite(16'hF060, 16'($urandom));
      busWrite(16'hF061, 16'($urandom));
      busWrite(16'hF062, 16'($urandom));
      busWrite(16'hF063, 16'($urandom));
      checkOutput("led_red", led_red, redM);
      checkOutput("led_green", {8'h0, led_green}, {8'h0, greenM});
      checkOutput("hex_lo", hex3_hex0, hexLoM);
      checkOutput("hex_hi", hex7_hex4, hexHiM);
      busReadCheck("read_green", 16'hF061);
      busReadCheck("read_hex_hi", 16'hF063);
    end
    switch = 16'hA5A5;
    busReadCheck("switch_a5a5", 16'hF064);
    button = 4'b1010;
    busReadCheck("button_a", 16'hF065);
    switch = 16'($urandom);
    busWrite(16'hF064, 16'h1234);
    busReadCheck("switch_ro", 16'hF064);
    busReadCheck("unmapped_8000", 16'h8000);
    busReadCheck("unmapped_f066", 16'hF066);
    busReadCheck("tx_data_reads0", 16'hF070);

    // UART receive
    sendRxFrame(8'h3C, 1'b1);
    busReadCheck("rx_stat_valid", 16'hF073);
    busReadCheck("rx_data_3c", 16'hF072);
    busReadCheck("rx_stat_cleared", 16'hF073);
    b1 = 8'($urandom); b2 = 8'($urandom);
    sendRxFrame(b1, 1'b1);
    sendRxFrame(b2, 1'b1);
    busReadCheck("rx_stat_overrun", 16'hF073);
    busWrite(16'hF073, 16'h0000);
    busReadCheck("rx_stat_errclr", 16'hF073);
    sendRxFrame(8'($urandom), 1'b0);
    busReadCheck("rx_stat_ferr", 16'hF073);
    busReadCheck("rx_data_kept", 16'hF072);
    busReadCheck("rx_stat_final", 16'hF073);

    // UART transmit of 0x55 with a write while busy
    busWrite(16'hF070, 16'h0055);
    checkOutput("tx55_start", {15'h0, tx_serial}, {15'h0, txLineAt(cycleCount)});
    for (int i = 0; i < 44; i++) begin
      if (i == 3) busReadCheck("tx55_busy", 16'hF071);
      else if (i == 5) busWrite(16'hF070, 16'h0000);
      else tick();
      checkOutput("tx55_bit", {15'h0, tx_serial}, {15'h0, txLineAt(cycleCount)});
    end
    busReadCheck("tx55_idle", 16'hF071);

    // Reset in the middle of a frame
    busWrite(16'hF070, 16'($urandom));
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    modelReset();
    checkOutput("midreset_tx", {15'h0, tx_serial}, 16'h0001);
    checkOutput("midreset_led_red", led_red, 16'h0000);
    lcd_index = 5'd5; #1;
    checkOutput("midreset_lcd5", {8'h0, lcd_char}, 16'h0020);
    rst_n = 1'b1;
    tick();
    busReadCheck("midreset_busy", 16'hF071);
    busReadCheck("midreset_rxstat", 16'hF073);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
